// File: rtl/seven_seg_mux_n.sv
// Purpose: N-digit multiplexed seven-segment driver with per-digit decimal points,
//          leading-zero suppression, PWM brightness and frame-aligned double buffering.
// Latency: outputs are registered, one cycle behind the scan state; loads reach the
//          display at the next frame boundary. No backpressure: load is always accepted.
//
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   digits            hex nibbles, digit i = digits[4i+3:4i], digit 0 rightmost
//   dp_in             per-digit decimal point request (active high)
//   lz_en             leading-zero suppression enable
//   brightness        PWM duty level, sampled live every cycle
//   load              one-cycle strobe capturing digits/dp_in/lz_en into the pending buffer
//   frame_start       one-cycle pulse aligned with the first output cycle of digit 0
//   anode             active-low digit enables
//   led_code          active-low cathodes, [7]=dp, [6:0]=a..g
module seven_seg_mux_n #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = 250000,
    parameter int DIM_BITS     = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   digits,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      lz_en,
    input  logic [DIM_BITS-1:0]       brightness,
    input  logic                      load,
    output logic                      frame_start,
    output logic [NUM_DIGITS-1:0]     anode,
    output logic [7:0]                led_code
);

    localparam int SW = $clog2(DIGIT_CYCLES);
    localparam int IW = $clog2(NUM_DIGITS);
    // Wide enough that (brightness+1)*DIGIT_CYCLES never overflows for any legal
    // DIGIT_CYCLES that fits in an int.
    localparam int PW = DIM_BITS + 33;

    // Scan state
    logic [SW-1:0]           slot_cnt_q, slot_cnt_d;
    logic [IW-1:0]           dig_idx_q, dig_idx_d;

    // Pending (written by load) and active (displayed) buffers
    logic [4*NUM_DIGITS-1:0] pend_digits_q, pend_digits_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pend_lz_q, pend_lz_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [4*NUM_DIGITS-1:0] act_digits_q, act_digits_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic                    act_lz_q, act_lz_d;

    // Registered outputs
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic [7:0]              led_code_q, led_code_d;
    logic                    frame_start_q, frame_start_d;

    logic                    slot_wrap, dig_wrap, frame_end;
    logic [PW-1:0]           on_cycles;
    logic                    lit;
    logic [3:0]              sel_nib;
    logic                    sel_dp;
    logic                    sel_blank;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   blank_mask;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Scan counters and buffer transfer
    always_comb begin
        slot_wrap = (slot_cnt_q == SW'(DIGIT_CYCLES - 1));
        dig_wrap  = (dig_idx_q == IW'(NUM_DIGITS - 1));
        frame_end = slot_wrap && dig_wrap;

        slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + SW'(1);
        dig_idx_d  = dig_idx_q;
        if (slot_wrap) begin
            dig_idx_d = dig_wrap ? '0 : dig_idx_q + IW'(1);
        end

        act_digits_d  = act_digits_q;
        act_dp_d      = act_dp_q;
        act_lz_d      = act_lz_q;
        pend_digits_d = pend_digits_q;
        pend_dp_d     = pend_dp_q;
        pend_lz_d     = pend_lz_q;
        pend_vld_d    = pend_vld_q;

        // Transfer uses the pending contents from before any same-cycle load.
        if (frame_end && pend_vld_q) begin
            act_digits_d = pend_digits_q;
            act_dp_d     = pend_dp_q;
            act_lz_d     = pend_lz_q;
            pend_vld_d   = 1'b0;
        end
        if (load) begin
            pend_digits_d = digits;
            pend_dp_d     = dp_in;
            pend_lz_d     = lz_en;
            pend_vld_d    = 1'b1;
        end
    end

    // Output generation from the current scan position and active buffer
    always_comb begin
        on_cycles = ((PW'(brightness) + PW'(1)) * PW'(DIGIT_CYCLES)) >> DIM_BITS;
        lit       = (PW'(slot_cnt_q) < on_cycles);

        // A digit is blank when it and every digit to its left is a zero without dp.
        zero_run   = 1'b1;
        blank_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run && (act_digits_q[4*i +: 4] == 4'h0) && !act_dp_q[i];
            blank_mask[i] = zero_run && act_lz_q && (i != 0);
        end

        sel_nib   = 4'h0;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig_idx_q == IW'(i)) begin
                sel_nib   = act_digits_q[4*i +: 4];
                sel_dp    = act_dp_q[i];
                sel_blank = blank_mask[i];
            end
        end

        anode_d    = '1;
        led_code_d = 8'hFF;
        if (lit) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                anode_d[i] = (dig_idx_q != IW'(i));
            end
            if (!sel_blank) begin
                led_code_d = {~sel_dp, seg7(sel_nib)};
            end
        end

        frame_start_d = (slot_cnt_q == '0) && (dig_idx_q == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            slot_cnt_q    <= '0;
            dig_idx_q     <= '0;
            pend_digits_q <= '0;
            pend_dp_q     <= '0;
            pend_lz_q     <= 1'b0;
            pend_vld_q    <= 1'b0;
            act_digits_q  <= '0;
            act_dp_q      <= '0;
            act_lz_q      <= 1'b0;
            anode_q       <= '1;
            led_code_q    <= 8'hFF;
            frame_start_q <= 1'b0;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            dig_idx_q     <= dig_idx_d;
            pend_digits_q <= pend_digits_d;
            pend_dp_q     <= pend_dp_d;
            pend_lz_q     <= pend_lz_d;
            pend_vld_q    <= pend_vld_d;
            act_digits_q  <= act_digits_d;
            act_dp_q      <= act_dp_d;
            act_lz_q      <= act_lz_d;
            anode_q       <= anode_d;
            led_code_q    <= led_code_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign anode       = anode_q;
    assign led_code    = led_code_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_mux_n.sv
// Purpose: self-checking bench for seven_seg_mux_n (4 digits, 8 cycles/slot, 2-bit dim).
// Latency: a time-based reference model predicts every output cycle into a queue.
// Backpressure: none; a monitor pops and compares one entry per clock.
module tb_seven_seg_mux_n;

    localparam int N  = 4;
    localparam int DC = 8;
    localparam int DB = 2;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [4*N-1:0]  digits = '0;
    logic [N-1:0]    dp_in = '0;
    logic            lz_en = 1'b0;
    logic [DB-1:0]   brightness = 2'd3;
    logic            load = 1'b0;
    logic            frame_start;
    logic [N-1:0]    anode;
    logic [7:0]      led_code;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [N-1:0] an;
        logic [7:0]   led;
        logic         fs;
    } exp_t;

    exp_t exp_q[$];

    seven_seg_mux_n #(.NUM_DIGITS(N), .DIGIT_CYCLES(DC), .DIM_BITS(DB)) dut (
        .clock       (clock),
        .reset       (reset),
        .digits      (digits),
        .dp_in       (dp_in),
        .lz_en       (lz_en),
        .brightness  (brightness),
        .load        (load),
        .frame_start (frame_start),
        .anode       (anode),
        .led_code    (led_code)
    );

    always #5 clock = ~clock;

    // Segment patterns a..g for hex 0..F
    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Reference model: display time t counts cycles since reset release; the
    // scan position is derived from it by division.
    int             m_t = 0;
    logic [4*N-1:0] m_pend_dig = '0, m_act_dig = '0;
    logic [N-1:0]   m_pend_dp = '0, m_act_dp = '0;
    logic           m_pend_lz = 1'b0, m_act_lz = 1'b0, m_pend_vld = 1'b0;

    always @(posedge clock) begin
        exp_t e;
        int d, s, on;
        bit blank;
        e.an  = '1;
        e.led = 8'hFF;
        e.fs  = 1'b0;
        if (reset) begin
            m_t = 0;
            m_pend_dig = '0; m_pend_dp = '0; m_pend_lz = 1'b0; m_pend_vld = 1'b0;
            m_act_dig = '0;  m_act_dp = '0;  m_act_lz = 1'b0;
        end else begin
            d  = (m_t / DC) % N;
            s  = m_t % DC;
            on = ((int'(brightness) + 1) * DC) >> DB;
            e.fs = (d == 0) && (s == 0);
            if (s < on) begin
                e.an[d] = 1'b0;
                blank = m_act_lz && (d != 0);
                for (int j = d; j < N; j++) begin
                    if (m_act_dig[4*j +: 4] != 4'h0 || m_act_dp[j]) blank = 1'b0;
                end
                if (!blank) e.led = {~m_act_dp[d], seg_tab[m_act_dig[4*d +: 4]]};
            end
            if (s == DC - 1 && d == N - 1 && m_pend_vld) begin
                m_act_dig = m_pend_dig; m_act_dp = m_pend_dp; m_act_lz = m_pend_lz;
                m_pend_vld = 1'b0;
            end
            if (load) begin
                m_pend_dig = digits; m_pend_dp = dp_in; m_pend_lz = lz_en;
                m_pend_vld = 1'b1;
            end
            m_t++;
        end
        exp_q.push_back(e);
    end

    // Monitor: one comparison per output cycle
    int mon_cycle = 0;
    always @(posedge clock) begin
        exp_t e;
        #1;
        mon_cycle++;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty cycle=%0d", mon_cycle);
        end else begin
            e = exp_q.pop_front();
            if (anode !== e.an || led_code !== e.led || frame_start !== e.fs) begin
                failures++;
                $display("FAIL scoreboard cycle=%0d anode=%b exp=%b led_code=%h exp=%h frame_start=%b exp=%b",
                         mon_cycle, anode, e.an, led_code, e.led, frame_start, e.fs);
            end
        end
    end

    task automatic chk(input string nm, input logic [N-1:0] ea, input logic [7:0] el, input logic efs);
        checks++;
        if (anode !== ea || led_code !== el || frame_start !== efs) begin
            failures++;
            $display("FAIL %s anode=%b exp=%b led_code=%h exp=%h frame_start=%b exp=%b",
                     nm, anode, ea, led_code, el, frame_start, efs);
        end
    endtask

    task automatic wait_frame(input string nm);
        int k;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (frame_start !== 1'b1 && k < 100);
        if (frame_start !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s frame_start_timeout cycles=%0d", nm, k);
        end
    endtask

    task automatic do_load(input logic [4*N-1:0] dg, input logic [N-1:0] dp, input logic lz);
        digits = dg;
        dp_in  = dp;
        lz_en  = lz;
        load   = 1'b1;
        @(negedge clock);
        load   = 1'b0;
    endtask

    // Checks each slot of the next frame (brightness 3 assumed).
    task automatic check_frame(input string nm, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0]   ev [4];
        logic [N-1:0] ea;
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
        wait_frame(nm);
        for (int k = 0; k < N; k++) begin
            ea = ~(N'(1) << k);
            chk(nm, ea, ev[k], k == 0);
            repeat (DC) @(negedge clock);
        end
    endtask

    task automatic check_duty(input string nm, input int on, input logic [7:0] el);
        wait_frame(nm);
        for (int k = 0; k < DC; k++) begin
            if (k < on) chk(nm, 4'b1110, el, k == 0);
            else        chk(nm, 4'b1111, 8'hFF, 1'b0);
            @(negedge clock);
        end
    endtask

    initial begin
        // Reset behaviour
        @(negedge clock);
        chk("reset_blank", 4'b1111, 8'hFF, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("post_reset_digit0", 4'b1110, 8'h81, 1'b1);
        check_frame("zeros", 8'h81, 8'h81, 8'h81, 8'h81);

        // Hex decode with decimal point
        do_load(16'h12AF, 4'b0100, 1'b0);
        check_frame("hex_12AF", 8'hB8, 8'h88, 8'h12, 8'hCF);

        // PWM brightness
        brightness = 2'd1;
        check_duty("duty_b1", 4, 8'hB8);
        brightness = 2'd0;
        check_duty("duty_b0", 2, 8'hB8);
        brightness = 2'd3;

        // Leading-zero suppression
        do_load(16'h0700, 4'b0000, 1'b1);
        check_frame("lz_0700", 8'h81, 8'h81, 8'h8F, 8'hFF);
        do_load(16'h0070, 4'b0000, 1'b1);
        check_frame("lz_0070", 8'h81, 8'h8F, 8'hFF, 8'hFF);
        do_load(16'h0000, 4'b0000, 1'b1);
        check_frame("lz_0000", 8'h81, 8'hFF, 8'hFF, 8'hFF);
        do_load(16'h0000, 4'b1000, 1'b1);
        check_frame("lz_dp3", 8'h81, 8'h81, 8'h81, 8'h01);

        // Mid-frame load: current frame keeps old data
        wait_frame("midload_sync");
        repeat (9) @(negedge clock);
        do_load(16'h5555, 4'b0000, 1'b0);
        repeat (8) @(negedge clock);
        chk("midload_old_digit2", 4'b1011, 8'h81, 1'b0);
        check_frame("midload_new", 8'hA4, 8'hA4, 8'hA4, 8'hA4);

        // Two loads in one frame: last wins
        wait_frame("twoload_sync");
        repeat (3) @(negedge clock);
        do_load(16'h3333, 4'b0000, 1'b0);
        repeat (5) @(negedge clock);
        do_load(16'h6666, 4'b0000, 1'b0);
        check_frame("twoload", 8'hA0, 8'hA0, 8'hA0, 8'hA0);

        // Reset mid-frame with a pending load
        wait_frame("rst_sync");
        repeat (17) @(negedge clock);
        do_load(16'h9999, 4'b0000, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("midreset_blank", 4'b1111, 8'hFF, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("midreset_restart", 4'b1110, 8'h81, 1'b1);
        check_frame("midreset_discard", 8'h81, 8'h81, 8'h81, 8'h81);

        // Randomized traffic checked by the scoreboard
        for (int c = 0; c < 3000; c++) begin
            logic [4*N-1:0] dg;
            dg = 16'($urandom);
            for (int n = 0; n < N; n++) begin
                if ($urandom_range(0, 1) == 0) dg[4*n +: 4] = 4'h0;
            end
            digits = dg;
            dp_in  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            lz_en  = 1'($urandom);
            load   = ($urandom_range(0, 15) == 0);
            reset  = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) brightness = DB'($urandom);
            @(negedge clock);
        end
        load  = 1'b0;
        reset = 1'b0;
        repeat (4) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
